// File: rtl/pulse_stretch_pkg.sv
// Shared types for the pulse stretcher: FSM state encoding and its width.
package pulse_stretch_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      IDLE    = 2'd0,
      STRETCH = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

endpackage

// File: rtl/pulse_stretch_load_dcnt.sv
// Loadable down-counter shared by the stretch and hold-off phases.
// Load has priority over decrement; the count saturates at zero instead of wrapping.
module load_dcnt #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_val,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_zero
);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_reg <= '0;
      end else if (i_load) begin
         cnt_reg <= i_val;
      end else if (i_dec && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign o_cnt  = cnt_reg;
   assign o_zero = (cnt_reg == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Pulse stretcher: a one-cycle trigger becomes an output level eff_len cycles wide,
// followed by an optional GAP-cycle hold-off. Retriggering is enabled by PULSE_STRETCH_RETRIGGER_EN.
module pulse_stretch
   import pulse_stretch_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int GAP   = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pulse,
   input  logic [CNT_W-1:0] i_len,
   output logic             o_out,
   output logic             o_busy,
   output logic             o_drop
);

   localparam bit               GAP_ON   = (GAP > 0);
   localparam logic [CNT_W-1:0] GAP_LOAD = GAP_ON ? CNT_W'(GAP - 1) : '0;

   state_t           state_reg;
   state_t           state_next;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             dec_req;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;
   logic             cnt_live;
   logic [CNT_W-1:0] eff_len_m1;
   logic             out_reg;
   logic             out_next;
   logic             busy_reg;
   logic             busy_next;
   logic             drop_reg;
   logic             drop_next;

   // A zero length still produces a one-cycle pulse, so the counter preload is len-1 floored at 0.
   assign eff_len_m1 = (i_len == '0) ? '0 : (i_len - 1'b1);
   assign cnt_live   = |cnt;

   load_dcnt #(
      .CNT_W (CNT_W)
   ) u_dcnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (load),
      .i_val  (load_val),
      .i_dec  (dec_req & cnt_live),
      .o_cnt  (cnt),
      .o_zero (cnt_zero)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      load_val   = '0;
      dec_req    = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (i_pulse) begin
               load       = 1'b1;
               load_val   = eff_len_m1;
               state_next = STRETCH;
            end
         end
         STRETCH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
            if (i_pulse) begin
               load     = 1'b1;
               load_val = eff_len_m1;
            end else if (!cnt_zero) begin
               dec_req = 1'b1;
            end else if (GAP_ON) begin
               load       = 1'b1;
               load_val   = GAP_LOAD;
               state_next = HOLDOFF;
            end else begin
               state_next = IDLE;
            end
`else
            if (!cnt_zero) begin
               dec_req = 1'b1;
            end else if (GAP_ON) begin
               load       = 1'b1;
               load_val   = GAP_LOAD;
               state_next = HOLDOFF;
            end else if (i_pulse) begin
               // Without hold-off, a trigger on the last cycle chains straight into a new stretch.
               load     = 1'b1;
               load_val = eff_len_m1;
            end else begin
               state_next = IDLE;
            end
`endif
         end
         HOLDOFF: begin
            if (cnt_zero) begin
               state_next = IDLE;
            end else begin
               dec_req = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // A trigger is accepted exactly when it loads the counter for a stretch.
   always_comb begin
      out_next  = (state_next == STRETCH);
      busy_next = (state_next != IDLE);
      drop_next = i_pulse && !(load && (state_next == STRETCH));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         out_reg  <= 1'b0;
         busy_reg <= 1'b0;
         drop_reg <= 1'b0;
      end else begin
         out_reg  <= out_next;
         busy_reg <= busy_next;
         drop_reg <= drop_next;
      end
   end

   assign o_out  = out_reg;
   assign o_busy = busy_reg;
   assign o_drop = drop_reg;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: records per-cycle output bitmaps and compares them with
// hand-derived masks. Two instances: GAP=2 (dut) and GAP=0 (dut0) share all inputs.
module tb_pulse_stretch;

   logic       clk;
   logic       rst;
   logic       pulse;
   logic [7:0] len;
   logic       o_out, o_busy, o_drop;
   logic       o_out0, o_busy0, o_drop0;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] out_h, busy_h, drop_h;
   logic [31:0] out0_h, busy0_h, drop0_h;

   pulse_stretch #(.CNT_W(8), .GAP(2)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_pulse (pulse),
      .i_len   (len),
      .o_out   (o_out),
      .o_busy  (o_busy),
      .o_drop  (o_drop)
   );

   pulse_stretch #(.CNT_W(8), .GAP(0)) dut0 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_pulse (pulse),
      .i_len   (len),
      .o_out   (o_out0),
      .o_busy  (o_busy0),
      .o_drop  (o_drop0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Bit c of each history is the output value seen just after edge c of the window.
   task automatic run(input string name, input logic [7:0] len0, input logic [7:0] len1,
                      input logic [31:0] pmask, input int rst_at);
      out_h = '0; busy_h = '0; drop_h = '0;
      out0_h = '0; busy0_h = '0; drop0_h = '0;
      for (int c = 0; c < 24; c++) begin
         len   = (c == 0) ? len0 : len1;
         pulse = pmask[c];
         rst   = (c == rst_at);
         @(posedge clk);
         #1;
         out_h[c]   = o_out;
         busy_h[c]  = o_busy;
         drop_h[c]  = o_drop;
         out0_h[c]  = o_out0;
         busy0_h[c] = o_busy0;
         drop0_h[c] = o_drop0;
      end
      pulse = 1'b0;
      rst   = 1'b0;
      $display("run %s: out=0x%08h busy=0x%08h drop=0x%08h out0=0x%08h",
               name, out_h, busy_h, drop_h, out0_h);
   endtask

   initial begin
      rst   = 1'b1;
      pulse = 1'b1;
      len   = 8'd5;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", {31'd0, o_out}, 32'd0);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_drop", {31'd0, o_drop}, 32'd0);
      rst   = 1'b0;
      pulse = 1'b0;
      @(posedge clk);
      #1;
      check("idle_out", {31'd0, o_out}, 32'd0);
      check("idle_busy", {31'd0, o_busy}, 32'd0);

      run("len5", 8'd5, 8'd5, 32'h1, -1);
      check("len5_out", out_h, 32'h1F);
      check("len5_busy", busy_h, 32'h7F);
      check("len5_drop", drop_h, 32'h0);

      run("len0", 8'd0, 8'd0, 32'h1, -1);
      check("len0_out", out_h, 32'h1);
      check("len0_busy", busy_h, 32'h7);

      run("retrig", 8'd8, 8'd8, 32'h9, -1);
`ifdef PULSE_STRETCH_RETRIGGER_EN
      check("retrig_out", out_h, 32'h7FF);
      check("retrig_busy", busy_h, 32'h1FFF);
      check("retrig_drop", drop_h, 32'h0);
`else
      check("retrig_out", out_h, 32'hFF);
      check("retrig_busy", busy_h, 32'h3FF);
      check("retrig_drop", drop_h, 32'h8);
`endif

      run("holdoff", 8'd3, 8'd3, 32'h49, -1);
      check("holdoff_out", out_h, 32'h1C7);
      check("holdoff_busy", busy_h, 32'h7DF);
      check("holdoff_drop", drop_h, 32'h8);

      run("gap0_chain", 8'd4, 8'd4, 32'h11, -1);
      check("gap0_out", out0_h, 32'hFF);
      check("gap0_busy", busy0_h, 32'hFF);
      check("gap0_drop", drop0_h, 32'h0);

      run("midreset", 8'd10, 8'd10, 32'h21, 3);
      check("midrst_out", out_h, 32'h7FE7);
      check("midrst_busy", busy_h, 32'h1FFE7);
      check("midrst_drop", drop_h, 32'h0);
      check("midrst_out0", out0_h, 32'h7FE7);

      run("lenchange", 8'd3, 8'd9, 32'h101, -1);
      check("lenchg_out", out_h, 32'h1FF07);
      check("lenchg_busy", busy_h, 32'h7FF1F);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
